mul_mantissa_sequencer: RTL and testbench
=========================================

# mul_mantissa_sequencer

Sequential mantissa multiplier controller for the FPU MUL path. It multiplies two unsigned MANT_W-bit mantissas by time-sharing one (MANT_W/3)x(MANT_W/3) partial-product multiplier across the nine slice products (A_i x B_j). Each slice product is accumulated at its shift of 8·(i+j) into a 2·MANT_W-bit product register. It sits between the operand-unpack stage and the MUL normalize/round stage, with a valid/ready handshake on both sides.

## Interface
- MANT_W, 24, mantissa width; must be a multiple of 3; slice width P = MANT_W/3 (8 at default)
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  operand valid; accepted only when InReady=1
- InReady  out  1  high in IDLE only
- MantA  in  MANT_W  multiplicand, unsigned, sampled on accept edge
- MantB  in  MANT_W  multiplier, unsigned, sampled on accept edge
- Flush  in  1  synchronous abort; returns to IDLE, drops any result
- Valid  out  1  Product valid; held until accepted
- OutReady  in  1  downstream accepts Product when Valid=1
- Product  out  2·MANT_W  A×B, stable while Valid=1
- Busy  out  1  high in MUL state

## Operation
- States: IDLE, MUL, DONE. Reset state is IDLE.
- Reset values: InReady=1, Valid=0, Busy=0, Product=0, slice counter=0, operand registers=0.
- IDLE
  - InReady=1.
  - Start=1 on an edge: latch MantA/MantB, clear the accumulator, set count=0, go to MUL.
- MUL
  - count runs 0..8 in order i = count/3 (A slice, 0 = LSB slice), j = count%3 (B slice).
  - Each edge: Acc ← Acc + ((A[P·i+:P] · B[P·j+:P]) << P·(i+j)); the slice product is exactly 2P bits.
  - Acc is 2·MANT_W bits wide; the full product cannot overflow, so the carry out of the MSB is discarded.
  - On the edge with count=8: perform the final accumulation, go to DONE, set Valid=1.
  - Start is ignored while in MUL (InReady=0).
- DONE
  - Valid=1 and Product=Acc, held stable.
  - Edge with OutReady=1: Valid←0, go to IDLE.
  - A Start arriving in the same cycle is not accepted; InReady rises on the following cycle.
- Flush=1 on any edge, from any state: go to IDLE, Valid←0, count←0. Product retains its value but is not valid. Flush has priority over Start and OutReady.
- ResetN low at any time, mid-operation included: all state immediately returns to the reset values. No partial result is ever flagged valid.
- Product equals Acc at all times; it is qualified only by Valid.

## Timing
- Accept edge = E0. Accumulation edges are E1..E9. Valid is high after E9.
- Latency from accept to Valid is 9 cycles. Throughput with OutReady tied high is one result per 11 cycles: accept, 9 MUL cycles, 1 DONE cycle. Back-to-back accept occurs on the edge after return to IDLE.
- Busy is high from after E0 through E9.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Flush during E1..E9 aborts the operation; InReady=1 on the next cycle.
- Back-pressure: Valid and Product hold indefinitely while OutReady=0.

## Test plan
- Basic: MantA=0x123456, MantB=0x000001, OutReady=1 -> Valid rises 9 cycles after accept; Product=0x000000123456; one-cycle Valid pulse; InReady high the following cycle.
- Full-scale: MantA=MantB=0xFFFFFF -> Product=0xFFFFFE000001. This checks every slice shift and the carry propagation across all accumulation steps.
- Normalized operands: 0x800000×0x800000 -> 0x400000000000; 0xC00000×0xA00000 -> 0x780000000000.
- Back-pressure: hold OutReady=0 for 5 cycles after Valid -> Product and Valid stable and Start ignored. On release, exactly one handshake occurs, then the next operand (0x000002×0x000003 -> 0x6) completes correctly.
- Abort: assert Flush at E4 of an operation -> IDLE next cycle, Valid never rises. The subsequent 0xFFFFFF×0x000001 -> 0x000000FFFFFF, showing no stale accumulator carried over.
- Reset: drive ResetN low asynchronously between edges during MUL -> InReady=1, Valid=0, Busy=0, Product=0 immediately, without waiting for a clock edge. After release, normal operation resumes.

Source files
------------

// File: rtl/mul_mantissa_sequencer_if.sv
// Handshake and data bundle between the operand-unpack stage, the
// sequential mantissa multiplier and the MUL normalize/round stage.
interface mul_mantissa_sequencer_if #(
    parameter int MANT_W = 24
);
    logic                  start;
    logic                  in_ready;
    logic [MANT_W-1:0]     mant_a;
    logic [MANT_W-1:0]     mant_b;
    logic                  flush;
    logic                  valid;
    logic                  out_ready;
    logic [2*MANT_W-1:0]   product;
    logic                  busy;

    // Upstream/downstream driver side.
    modport master (
        output start, mant_a, mant_b, flush, out_ready,
        input  in_ready, valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  start, mant_a, mant_b, flush, out_ready,
        output in_ready, valid, product, busy
    );
endinterface

// File: rtl/mul_mantissa_sequencer.sv
// Sequential mantissa multiplier: one PxP multiplier (P = MANT_W/3) is reused
// over nine cycles, one slice pair A_i x B_j per cycle, accumulating each
// slice product at shift P*(i+j) into a 2*MANT_W-bit accumulator.
module mul_mantissa_sequencer #(
    parameter int MANT_W = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    mul_mantissa_sequencer_if.slave   bus
);
    localparam int P  = MANT_W / 3;
    localparam int PW = 2 * MANT_W;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MANT_W-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              valid_q, valid_d;

    logic [1:0]        sel_i, sel_j;
    logic [P-1:0]      a_sl, b_sl;
    logic [2*P-1:0]    pp;
    logic [PW-1:0]     pp_ext, pp_sh;

    // Decode the slice counter into (A slice, B slice) = (cnt/3, cnt%3).
    always_comb begin
        sel_i = 2'd0;
        sel_j = 2'd0;
        case (cnt_q)
            4'd0: begin sel_i = 2'd0; sel_j = 2'd0; end
            4'd1: begin sel_i = 2'd0; sel_j = 2'd1; end
            4'd2: begin sel_i = 2'd0; sel_j = 2'd2; end
            4'd3: begin sel_i = 2'd1; sel_j = 2'd0; end
            4'd4: begin sel_i = 2'd1; sel_j = 2'd1; end
            4'd5: begin sel_i = 2'd1; sel_j = 2'd2; end
            4'd6: begin sel_i = 2'd2; sel_j = 2'd0; end
            4'd7: begin sel_i = 2'd2; sel_j = 2'd1; end
            4'd8: begin sel_i = 2'd2; sel_j = 2'd2; end
            default: begin sel_i = 2'd0; sel_j = 2'd0; end
        endcase
    end

    // Shared slice multiplier; the product is exactly 2P bits, then aligned.
    always_comb begin
        a_sl   = a_q[int'(sel_i)*P +: P];
        b_sl   = b_q[int'(sel_j)*P +: P];
        pp     = {{P{1'b0}}, a_sl} * {{P{1'b0}}, b_sl};
        pp_ext = {{(PW-2*P){1'b0}}, pp};
        pp_sh  = pp_ext << (P * (int'(sel_i) + int'(sel_j)));
    end

    // Next-state logic; Flush overrides everything but keeps the accumulator.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.mant_a;
                    b_d     = bus.mant_b;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                // Full product fits in PW bits, so the carry out is dropped.
                acc_d = acc_q + pp_sh;
                if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            cnt_d   = 4'd0;
            a_d     = a_q;
            b_d     = b_q;
            acc_d   = acc_q;
        end
    end

    // State and datapath registers with async active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

    // Outputs come straight from registers or decode of the state register.
    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q == S_MUL);
    assign bus.valid    = valid_q;
    assign bus.product  = acc_q;

endmodule

// File: tb/tb_mul_mantissa_sequencer.sv
// Directed self-checking bench for mul_mantissa_sequencer (MANT_W = 24).
module tb_mul_mantissa_sequencer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mul_mantissa_sequencer_if #(.MANT_W(24)) bus ();

    mul_mantissa_sequencer #(.MANT_W(24)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and check latency and result; caller sets out_ready.
    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [47:0] exp);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.mant_a = a;
        bus.mant_b = b;
        bus.start  = 1'b1;
        tick();                 // E0
        bus.start  = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        repeat (8) tick();      // E1..E8
        check({tag, "_valid_early"}, 64'(bus.valid), 64'd0);
        tick();                 // E9
        check({tag, "_valid"}, 64'(bus.valid), 64'd1);
        check({tag, "_product"}, 64'(bus.product), 64'(exp));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    endtask

    // Complete a handshake with out_ready already high.
    task automatic finish_op(input string tag);
        tick();
        check({tag, "_valid_drop"}, 64'(bus.valid), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mant_a = '0;
        bus.mant_b = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_valid",    64'(bus.valid),    64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_product",  64'(bus.product),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic
        run_op("basic", 24'h123456, 24'h000001, 48'h000000123456);
        finish_op("basic");

        // Full-scale and normalized operands
        run_op("full", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        finish_op("full");
        run_op("norm1", 24'h800000, 24'h800000, 48'h400000000000);
        finish_op("norm1");
        run_op("norm2", 24'hC00000, 24'hA00000, 48'h780000000000);
        finish_op("norm2");

        // Back-pressure: hold Valid/Product, Start ignored
        bus.out_ready = 1'b0;
        run_op("bp", 24'h000ABC, 24'h000100, 48'h00000ABC00);
        bus.start  = 1'b1;
        bus.mant_a = 24'h000002;
        bus.mant_b = 24'h000003;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid",   64'(bus.valid),    64'd1);
            check("bp_hold_product", 64'(bus.product),  64'h00000ABC00);
            check("bp_hold_ready",   64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();                 // handshake edge; start in same cycle not accepted
        check("bp_release_valid", 64'(bus.valid),    64'd0);
        check("bp_release_busy",  64'(bus.busy),     64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        bus.start = 1'b0;
        run_op("bp_next", 24'h000002, 24'h000003, 48'h6);
        finish_op("bp_next");

        // Abort with Flush at E4
        bus.mant_a = 24'h654321;
        bus.mant_b = 24'h777777;
        bus.start  = 1'b1;
        tick();                 // E0
        bus.start  = 1'b0;
        repeat (3) tick();      // E1..E3
        bus.flush  = 1'b1;
        tick();                 // E4
        bus.flush  = 1'b0;
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        check("flush_valid", 64'(bus.valid),    64'd0);
        check("flush_busy",  64'(bus.busy),     64'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("flush_no_valid", 64'(bus.valid), 64'd0);
        end
        run_op("post_flush", 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF);
        finish_op("post_flush");

        // Asynchronous reset mid-operation
        bus.mant_a = 24'hFFFFFF;
        bus.mant_b = 24'hFFFFFF;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_valid",    64'(bus.valid),    64'd0);
        check("arst_busy",     64'(bus.busy),     64'd0);
        check("arst_product",  64'(bus.product),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 24'h000010, 24'h000010, 48'h100);
        finish_op("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
